// File: rtl/joybus_pkg.sv
// Shared definitions for the Joybus host command path.
//   JB_CMD_ORIGIN / JB_CMD_POLL : command bytes issued to the transmitter
//   jb_sched_state_t            : scheduler state encoding
//   cnt_width()                 : counter width for a 0..n-1 counter; never
//                                 below 1 bit so that n = 1 or 2 still yields
//                                 a legal vector
package joybus_pkg;

   localparam logic [7:0] JB_CMD_ORIGIN = 8'h00;
   localparam logic [7:0] JB_CMD_POLL   = 8'h01;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TX      = 2'd1,
      RX_WAIT = 2'd2,
      GAP     = 2'd3
   } jb_sched_state_t;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/joybus_cmd_sched_if.sv
// Handshake bundle between the host request logic, the Joybus tx/rx pair
// and the command scheduler.
//   slave  : scheduler view (requests and tx/rx status in, command and
//            controller data out)
//   master : host/tx/rx view (drives requests and tx/rx status)
// Signals:
//   req_origin, req_poll : single-cycle manual requests
//   auto_poll_en         : level enable for the periodic poll timer
//   tx_done, rx_done     : single-cycle completion pulses; rx_data valid with rx_done
//   cmd_rdy, cmd_data    : start strobe and command byte to the transmitter
//   busy                 : scheduler not idle
//   cntlr_data/vld       : last controller word and its update pulse
//   resp_cmd             : command byte that produced cntlr_data
//   no_resp              : receive timeout pulse
interface joybus_cmd_sched_if;

   logic        req_origin;
   logic        req_poll;
   logic        auto_poll_en;
   logic        tx_done;
   logic        rx_done;
   logic [31:0] rx_data;

   logic        cmd_rdy;
   logic [7:0]  cmd_data;
   logic        busy;
   logic [31:0] cntlr_data;
   logic        cntlr_vld;
   logic [7:0]  resp_cmd;
   logic        no_resp;

   modport slave (
      input  req_origin, req_poll, auto_poll_en, tx_done, rx_done, rx_data,
      output cmd_rdy, cmd_data, busy, cntlr_data, cntlr_vld, resp_cmd, no_resp
   );

   modport master (
      output req_origin, req_poll, auto_poll_en, tx_done, rx_done, rx_data,
      input  cmd_rdy, cmd_data, busy, cntlr_data, cntlr_vld, resp_cmd, no_resp
   );

endinterface

// File: rtl/joybus_poll_timer.sv
// Periodic auto-poll tick generator.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable; when low the counter is held at 0
//   tick       : one-cycle pulse on the cycle the counter sits at
//                POLL_CYCLES-1, i.e. once every POLL_CYCLES enabled clocks
module joybus_poll_timer
   import joybus_pkg::*;
#(
   parameter int POLL_CYCLES = 500000
)(
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int            CW       = cnt_width(POLL_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(POLL_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (!en) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         tick  = 1'b1;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/joybus_cmd_sched.sv
// Joybus host command scheduler.
// Arbitrates ORIGIN requests, POLL requests and the periodic auto-poll tick,
// issues one command at a time to the transmitter, waits for a response or a
// timeout, latches the controller word, then holds a guard gap.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   sif        : joybus_cmd_sched_if.slave (requests, tx/rx status in;
//                command strobe/byte, busy, controller data, status out)
// Parameters:
//   POLL_CYCLES       : clocks between auto-poll ticks (>= 2)
//   RX_TIMEOUT_CYCLES : clocks allowed in RX_WAIT (>= 1)
//   GAP_CYCLES        : guard clocks after each transaction (>= 1)
// Build option:
//   JB_SCHED_AUTO_POLL_EN : compiles in the auto-poll timer and its pending
//                           flag; without it auto_poll_en is ignored.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing in flight; grants the highest pending request
// TX      | command strobed, waiting for tx_done
// RX_WAIT | waiting for rx_done, bounded by RX_TIMEOUT_CYCLES
// GAP     | guard interval before the next grant
module joybus_cmd_sched
   import joybus_pkg::*;
#(
   parameter int POLL_CYCLES       = 500000,
   parameter int RX_TIMEOUT_CYCLES = 2500,
   parameter int GAP_CYCLES        = 250
)(
   input  logic                clk,
   input  logic                rst_n,
   joybus_cmd_sched_if.slave   sif
);

   localparam int            RW      = cnt_width(RX_TIMEOUT_CYCLES);
   localparam int            GW      = cnt_width(GAP_CYCLES);
   localparam logic [RW-1:0] RX_LAST = RW'(RX_TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   jb_sched_state_t state_q, state_d;
   logic [RW-1:0]   rx_cnt_q, rx_cnt_d;
   logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
   logic [7:0]      cmd_data_q, cmd_data_d;
   logic            cmd_rdy_q, cmd_rdy_d;
   logic [31:0]     cntlr_data_q, cntlr_data_d;
   logic [7:0]      resp_cmd_q, resp_cmd_d;
   logic            cntlr_vld_q, cntlr_vld_d;
   logic            no_resp_q, no_resp_d;
   logic            pend_origin_q, pend_origin_d;
   logic            pend_poll_q, pend_poll_d;
   logic            grant_origin, grant_poll, grant_auto;

`ifdef JB_SCHED_AUTO_POLL_EN
   logic poll_tick;
   logic pend_auto_q, pend_auto_d;

   joybus_poll_timer #(
      .POLL_CYCLES (POLL_CYCLES)
   ) u_poll_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (sif.auto_poll_en),
      .tick  (poll_tick)
   );

   // Disabling auto-poll also withdraws a tick that has not been granted yet.
   always_comb begin
      pend_auto_d = 1'b0;
      if (sif.auto_poll_en) begin
         pend_auto_d = (pend_auto_q | poll_tick) & ~grant_auto;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_auto_q <= 1'b0;
      end else begin
         pend_auto_q <= pend_auto_d;
      end
   end
`else
   logic pend_auto_q;
   logic unused_auto;

   assign pend_auto_q = 1'b0;
   assign unused_auto = sif.auto_poll_en | grant_auto;
`endif

   // Clearing on grant wins over a request in the same cycle, so a request
   // coinciding with its own grant is absorbed.
   always_comb begin
      pend_origin_d = (pend_origin_q | sif.req_origin) & ~grant_origin;
      pend_poll_d   = (pend_poll_q   | sif.req_poll)   & ~grant_poll;
   end

   always_comb begin
      state_d      = state_q;
      rx_cnt_d     = rx_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      cmd_data_d   = cmd_data_q;
      cntlr_data_d = cntlr_data_q;
      resp_cmd_d   = resp_cmd_q;
      cmd_rdy_d    = 1'b0;
      cntlr_vld_d  = 1'b0;
      no_resp_d    = 1'b0;
      grant_origin = 1'b0;
      grant_poll   = 1'b0;
      grant_auto   = 1'b0;

      case (state_q)
         IDLE: begin
            if (pend_origin_q) begin
               grant_origin = 1'b1;
               cmd_data_d   = JB_CMD_ORIGIN;
               cmd_rdy_d    = 1'b1;
               state_d      = TX;
            end else if (pend_poll_q) begin
               grant_poll = 1'b1;
               cmd_data_d = JB_CMD_POLL;
               cmd_rdy_d  = 1'b1;
               state_d    = TX;
            end else if (pend_auto_q) begin
               grant_auto = 1'b1;
               cmd_data_d = JB_CMD_POLL;
               cmd_rdy_d  = 1'b1;
               state_d    = TX;
            end
         end

         TX: begin
            if (sif.tx_done) begin
               rx_cnt_d = '0;
               state_d  = RX_WAIT;
            end
         end

         RX_WAIT: begin
            // A response on the timeout cycle still counts as a response.
            if (sif.rx_done) begin
               cntlr_data_d = sif.rx_data;
               resp_cmd_d   = cmd_data_q;
               cntlr_vld_d  = 1'b1;
               gap_cnt_d    = '0;
               state_d      = GAP;
            end else if (rx_cnt_q == RX_LAST) begin
               no_resp_d = 1'b1;
               gap_cnt_d = '0;
               state_d   = GAP;
            end else begin
               rx_cnt_d = rx_cnt_q + RW'(1);
            end
         end

         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rx_cnt_q      <= '0;
         gap_cnt_q     <= '0;
         cmd_data_q    <= '0;
         cmd_rdy_q     <= 1'b0;
         cntlr_data_q  <= '0;
         resp_cmd_q    <= '0;
         cntlr_vld_q   <= 1'b0;
         no_resp_q     <= 1'b0;
         pend_origin_q <= 1'b0;
         pend_poll_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         rx_cnt_q      <= rx_cnt_d;
         gap_cnt_q     <= gap_cnt_d;
         cmd_data_q    <= cmd_data_d;
         cmd_rdy_q     <= cmd_rdy_d;
         cntlr_data_q  <= cntlr_data_d;
         resp_cmd_q    <= resp_cmd_d;
         cntlr_vld_q   <= cntlr_vld_d;
         no_resp_q     <= no_resp_d;
         pend_origin_q <= pend_origin_d;
         pend_poll_q   <= pend_poll_d;
      end
   end

   assign sif.cmd_rdy    = cmd_rdy_q;
   assign sif.cmd_data   = cmd_data_q;
   assign sif.busy       = (state_q != IDLE);
   assign sif.cntlr_data = cntlr_data_q;
   assign sif.cntlr_vld  = cntlr_vld_q;
   assign sif.resp_cmd   = resp_cmd_q;
   assign sif.no_resp    = no_resp_q;

endmodule

// File: tb/tb_joybus_cmd_sched.sv
module tb_joybus_cmd_sched;

   localparam int POLL  = 16;
   localparam int RX_TO = 8;
   localparam int GAP   = 4;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   cyc;
   int   last_grant;

   logic [7:0]  exp_cmd_q[$];
   logic [39:0] exp_rsp_q[$];

   joybus_cmd_sched_if jif();

   joybus_cmd_sched #(
      .POLL_CYCLES       (POLL),
      .RX_TIMEOUT_CYCLES (RX_TO),
      .GAP_CYCLES        (GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (jif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  32'(jif.busy),       32'd0);
      chk({tag, "_rdy"},   32'(jif.cmd_rdy),    32'd0);
      chk({tag, "_cmd"},   32'(jif.cmd_data),   32'd0);
      chk({tag, "_cdata"}, jif.cntlr_data,      32'd0);
      chk({tag, "_vld"},   32'(jif.cntlr_vld),  32'd0);
      chk({tag, "_rcmd"},  32'(jif.resp_cmd),   32'd0);
      chk({tag, "_nresp"}, 32'(jif.no_resp),    32'd0);
   endtask

   task automatic wait_cmd(input string tag, input int limit);
      int n;
      logic [7:0] e;
      n = 0;
      while (jif.cmd_rdy !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_grant"}, 32'(jif.cmd_rdy), 32'd1);
      if (jif.cmd_rdy === 1'b1) begin
         last_grant = cyc;
         if (exp_cmd_q.size() == 0) begin
            chk({tag, "_extra_grant"}, 32'(exp_cmd_q.size()), 32'd1);
         end else begin
            e = exp_cmd_q.pop_front();
            chk({tag, "_cmd"}, 32'(jif.cmd_data), 32'(e));
         end
      end
   endtask

   task automatic wait_rsp(input string tag, input int limit);
      int n;
      logic [7:0]  ec;
      logic [31:0] ed;
      n = 0;
      while (jif.cntlr_vld !== 1'b1 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_vld"}, 32'(jif.cntlr_vld), 32'd1);
      if (jif.cntlr_vld === 1'b1) begin
         if (exp_rsp_q.size() == 0) begin
            chk({tag, "_extra_rsp"}, 32'(exp_rsp_q.size()), 32'd1);
         end else begin
            {ec, ed} = exp_rsp_q.pop_front();
            chk({tag, "_cdata"}, jif.cntlr_data, ed);
            chk({tag, "_rcmd"}, 32'(jif.resp_cmd), 32'(ec));
         end
      end
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n;
      n = 0;
      while (jif.busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, 32'(jif.busy), 32'd0);
   endtask

   task automatic watch(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (jif.cmd_rdy === 1'b1) cnt++;
      end
   endtask

   task automatic tx_pulse();
      jif.tx_done = 1'b1;
      @(negedge clk);
      jif.tx_done = 1'b0;
   endtask

   task automatic rx_pulse(input logic [31:0] d);
      jif.rx_done = 1'b1;
      jif.rx_data = d;
      @(negedge clk);
      jif.rx_done = 1'b0;
   endtask

   initial begin
      int cnt;
      int g1;
      int t_entry;
      int n;
      int prev;

      total = 0;
      bad = 0;
      last_grant = 0;
      rst_n = 1'b0;
      jif.req_origin   = 1'b0;
      jif.req_poll     = 1'b0;
      jif.auto_poll_en = 1'b0;
      jif.tx_done      = 1'b0;
      jif.rx_done      = 1'b0;
      jif.rx_data      = 32'd0;

      // reset state
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // ORIGIN: one-cycle grant latency, single-cycle strobe, response latch
      exp_cmd_q.push_back(8'h00);
      jif.req_origin = 1'b1;
      @(negedge clk);
      jif.req_origin = 1'b0;
      chk("t1_early", 32'(jif.cmd_rdy), 32'd0);
      @(negedge clk);
      wait_cmd("t1", 0);
      chk("t1_busy", 32'(jif.busy), 32'd1);
      @(negedge clk);
      chk("t1_width", 32'(jif.cmd_rdy), 32'd0);
      chk("t1_hold", 32'(jif.cmd_data), 32'h00);
      tx_pulse();
      exp_rsp_q.push_back({8'h00, 32'h1234_5678});
      rx_pulse(32'h1234_5678);
      wait_rsp("t1", 0);
      @(negedge clk);
      chk("t1_vld_width", 32'(jif.cntlr_vld), 32'd0);
      wait_idle("t1", 20);

      // ORIGIN + POLL together: priority, minimum spacing, then RX timeout
      exp_cmd_q.push_back(8'h00);
      exp_cmd_q.push_back(8'h01);
      jif.req_origin = 1'b1;
      jif.req_poll   = 1'b1;
      @(negedge clk);
      jif.req_origin = 1'b0;
      jif.req_poll   = 1'b0;
      @(negedge clk);
      wait_cmd("t2a", 0);
      g1 = last_grant;
      tx_pulse();
      exp_rsp_q.push_back({8'h00, 32'hA5A5_0001});
      rx_pulse(32'hA5A5_0001);
      wait_rsp("t2a", 0);
      wait_cmd("t2b", 20);
      chk("t2_spacing", 32'(last_grant - g1), 32'(GAP + 3));
      tx_pulse();
      t_entry = cyc;
      n = 0;
      while (jif.no_resp !== 1'b1 && n < RX_TO + 5) begin
         @(negedge clk);
         n++;
      end
      chk("t2_no_resp", 32'(jif.no_resp), 32'd1);
      chk("t2_to_lat", 32'(cyc - t_entry), 32'(RX_TO));
      chk("t2_to_vld", 32'(jif.cntlr_vld), 32'd0);
      chk("t2_to_cdata", jif.cntlr_data, 32'hA5A5_0001);
      chk("t2_to_rcmd", 32'(jif.resp_cmd), 32'h00);
      @(negedge clk);
      chk("t2_nr_width", 32'(jif.no_resp), 32'd0);
      wait_idle("t2", 20);

      // rx_done on the timeout cycle wins; two POLL requests while busy merge
      exp_cmd_q.push_back(8'h01);
      jif.req_poll = 1'b1;
      @(negedge clk);
      jif.req_poll = 1'b0;
      wait_cmd("t3", 2);
      tx_pulse();
      exp_cmd_q.push_back(8'h01);
      jif.req_poll = 1'b1;
      @(negedge clk);
      jif.req_poll = 1'b0;
      @(negedge clk);
      jif.req_poll = 1'b1;
      @(negedge clk);
      jif.req_poll = 1'b0;
      repeat (RX_TO - 4) @(negedge clk);
      exp_rsp_q.push_back({8'h01, 32'hCAFE_F00D});
      rx_pulse(32'hCAFE_F00D);
      wait_rsp("t3", 0);
      chk("t3_no_resp", 32'(jif.no_resp), 32'd0);
      rx_pulse(32'hDEAD_BEEF);
      chk("t3_rx_ign_vld", 32'(jif.cntlr_vld), 32'd0);
      chk("t3_rx_ign_data", jif.cntlr_data, 32'hCAFE_F00D);
      wait_cmd("t3m", 20);
      tx_pulse();
      exp_rsp_q.push_back({8'h01, 32'h0000_0042});
      rx_pulse(32'h0000_0042);
      wait_rsp("t3m", 0);
      wait_idle("t3m", 20);
      watch(20, cnt);
      chk("t3_merge", 32'(cnt), 32'd0);
      tx_pulse();
      chk("t3_tx_ign", 32'(jif.busy), 32'd0);

      // request coinciding with its own grant is absorbed
      exp_cmd_q.push_back(8'h01);
      jif.req_poll = 1'b1;
      @(negedge clk);
      @(negedge clk);
      jif.req_poll = 1'b0;
      wait_cmd("t4", 0);
      tx_pulse();
      exp_rsp_q.push_back({8'h01, 32'h0000_1111});
      rx_pulse(32'h0000_1111);
      wait_rsp("t4", 0);
      wait_idle("t4", 20);
      watch(20, cnt);
      chk("t4_absorb", 32'(cnt), 32'd0);

`ifdef JB_SCHED_AUTO_POLL_EN
      // periodic auto-poll, then disable while a tick is pending
      jif.auto_poll_en = 1'b1;
      t_entry = cyc;
      prev = 0;
      for (int i = 0; i < 2; i++) begin
         exp_cmd_q.push_back(8'h01);
         wait_cmd("t5", 3 * POLL);
         if (i == 0) chk("t5_first", 32'(last_grant - t_entry), 32'(POLL + 1));
         else        chk("t5_period", 32'(last_grant - prev), 32'(POLL));
         prev = last_grant;
         tx_pulse();
         exp_rsp_q.push_back({8'h01, 32'(i)});
         rx_pulse(32'(i));
         wait_rsp("t5", 0);
      end
      exp_cmd_q.push_back(8'h01);
      wait_cmd("t5c", 3 * POLL);
      chk("t5_period_c", 32'(last_grant - prev), 32'(POLL));
      repeat (POLL + 4) @(negedge clk);
      jif.auto_poll_en = 1'b0;
      @(negedge clk);
      tx_pulse();
      exp_rsp_q.push_back({8'h01, 32'h0000_0077});
      rx_pulse(32'h0000_0077);
      wait_rsp("t5c", 0);
      wait_idle("t5c", 20);
      watch(3 * POLL, cnt);
      chk("t5_drop", 32'(cnt), 32'd0);
`else
      // auto_poll_en has no effect in this build
      jif.auto_poll_en = 1'b1;
      watch(3 * POLL, cnt);
      chk("t5_ignored", 32'(cnt), 32'd0);
      chk("t5_ign_busy", 32'(jif.busy), 32'd0);
      jif.auto_poll_en = 1'b0;
`endif

      // async reset mid-RX_WAIT with a POLL pending
      exp_cmd_q.push_back(8'h00);
      jif.req_origin = 1'b1;
      @(negedge clk);
      jif.req_origin = 1'b0;
      wait_cmd("t6", 2);
      tx_pulse();
      jif.req_poll = 1'b1;
      @(negedge clk);
      jif.req_poll = 1'b0;
      @(negedge clk);
      chk("t6_busy_pre", 32'(jif.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_zero("t6_rst");
      @(negedge clk);
      rst_n = 1'b1;
      watch(20, cnt);
      chk("t6_no_stale", 32'(cnt), 32'd0);
      chk_zero("t6_after");

      chk("sb_cmd_left", 32'(exp_cmd_q.size()), 32'd0);
      chk("sb_rsp_left", 32'(exp_rsp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
